// File: rtl/adat_frame_decoder_par.sv
// adat_frame_decoder_par
// Frames the NRZI-decoded ADAT bitstream into user bits and per-channel samples.
// Each complete sample is written MSB-aligned into a circular RAM of frames.
// A frame becomes visible to the reader only when it commits: that updates the
// last-good index, user bits and mode, and pulses frame_valid_o. An aborted
// frame bumps a saturating error counter, and its slot is reused by the next frame.
module adat_frame_decoder_par #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int NUM_CHANNELS  = 8,
    parameter int SAMPLE_BITS   = 24,
    parameter int WORD_BITS     = 32,
    parameter int ERR_CNT_BITS  = 8
) (
    input  logic                                           clk_x4_i,
    input  logic                                           reset_ni,
    input  logic                                           clk_main_tick_ni,
    input  logic                                           bit_i,
    input  logic                                           bit_valid_i,
    input  logic                                           sync_i,
    input  logic                                           smux_i,
    output logic                                           ram_we_o,
    output logic [CIRC_BUF_BITS+$clog2(NUM_CHANNELS)-1:0]  ram_addr_o,
    output logic [WORD_BITS-1:0]                           ram_data_o,
    output logic                                           frame_valid_o,
    output logic [CIRC_BUF_BITS-1:0]                       last_good_frame_idx_o,
    output logic [3:0]                                     user_bits_o,
    output logic                                           smux_o,
    output logic                                           has_sync_o,
    output logic [ERR_CNT_BITS-1:0]                        err_count_o
);
    localparam int CH_BITS  = $clog2(NUM_CHANNELS);
    localparam int NIBBLES  = SAMPLE_BITS / 4;
    localparam int NIB_BITS = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_BITS-1:0]     NIB_LAST = NIB_BITS'(NIBBLES - 1);
    localparam logic [CH_BITS-1:0]      CH_LAST  = CH_BITS'(NUM_CHANNELS - 1);
    localparam logic [ERR_CNT_BITS-1:0] ERR_MAX  = {ERR_CNT_BITS{1'b1}};

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitSync = 3'd1,
        StUser     = 3'd2,
        StSamples  = 3'd3,
        StCommit   = 3'd4,
        StError    = 3'd5
    } state_t;

    // In SMUX2 mode the channel LSB selects the subsample, so it becomes the slot MSB.
    function automatic logic [CH_BITS-1:0] smux_slot(input logic [CH_BITS-1:0] ch);
        logic [CH_BITS-1:0] r;
        r = ch >> 1;
        r[CH_BITS-1] = ch[0];
        return r;
    endfunction

    state_t                     state_r, state_s;
    logic [1:0]                 sync_q_r;
    logic                       smux_frame_r;
    logic [3:0]                 user_sr_r;
    logic [1:0]                 user_cnt_r;
    logic [2:0]                 phase_r;        // 0 = marker bit, 1..4 = data bits of a nibble
    logic [NIB_BITS-1:0]        nib_r;
    logic [CH_BITS-1:0]         ch_r;
    logic [SAMPLE_BITS-2:0]     sample_r;       // last data bit is taken directly from bit_i
    logic [CIRC_BUF_BITS-1:0]   frame_slot_r;
    logic                       start_s, user_s, marker_s, data_s, write_s;
    logic                       commit_s, error_s, lock_lost_s;
    logic [WORD_BITS-1:0]       word_s;
    logic [CH_BITS-1:0]         slot_s;

    // Next-state and per-tick control decode
    always_comb begin
        state_s     = state_r;
        start_s     = 1'b0;
        user_s      = 1'b0;
        marker_s    = 1'b0;
        data_s      = 1'b0;
        write_s     = 1'b0;
        commit_s    = 1'b0;
        error_s     = 1'b0;
        lock_lost_s = 1'b0;
        case (state_r)
            StIdle: state_s = StWaitSync;
            StWaitSync: begin
                if (!bit_valid_i) begin
                    lock_lost_s = 1'b1;
                end else begin
                    lock_lost_s = 1'b0;
                end
                if ((sync_q_r == 2'd3) && bit_i && bit_valid_i) begin
                    start_s = 1'b1;
                    state_s = StUser;
                end else begin
                    state_s = StWaitSync;
                end
            end
            StUser: begin
                if (!bit_valid_i || sync_i) begin
                    state_s = StError;
                end else begin
                    user_s = 1'b1;
                    if (user_cnt_r == 2'd3) begin
                        state_s = StSamples;
                    end else begin
                        state_s = StUser;
                    end
                end
            end
            StSamples: begin
                if (!bit_valid_i || sync_i) begin
                    state_s = StError;
                end else if (phase_r == 3'd0) begin
                    if (!bit_i) begin
                        state_s = StError;
                    end else begin
                        marker_s = 1'b1;
                        state_s  = StSamples;
                    end
                end else begin
                    data_s = 1'b1;
                    if ((phase_r == 3'd4) && (nib_r == NIB_LAST)) begin
                        write_s = 1'b1;
                        if (ch_r == CH_LAST) begin
                            state_s = StCommit;
                        end else begin
                            state_s = StSamples;
                        end
                    end else begin
                        state_s = StSamples;
                    end
                end
            end
            StCommit: begin
                commit_s = 1'b1;
                state_s  = StWaitSync;
            end
            StError: begin
                error_s = 1'b1;
                state_s = StWaitSync;
            end
            default: state_s = StIdle;
        endcase
    end

    // Write word and RAM slot for the sample completing on this tick
    always_comb begin
        word_s = {WORD_BITS{1'b0}};
        word_s[WORD_BITS-1 -: SAMPLE_BITS] = {sample_r, bit_i};
        if (smux_frame_r) begin
            slot_s = smux_slot(ch_r);
        end else begin
            slot_s = ch_r;
        end
    end

    // State register, advanced only on bit ticks
    always_ff @(posedge clk_x4_i) begin
        if (!reset_ni) begin
            state_r <= StIdle;
        end else if (!clk_main_tick_ni) begin
            state_r <= state_s;
        end
    end

    // One-clock strobes: set on the tick edge, dropped on the following edge
    always_ff @(posedge clk_x4_i) begin
        if (!reset_ni) begin
            ram_we_o      <= 1'b0;
            frame_valid_o <= 1'b0;
        end else if (!clk_main_tick_ni) begin
            ram_we_o      <= write_s;
            frame_valid_o <= commit_s;
        end else begin
            ram_we_o      <= 1'b0;
            frame_valid_o <= 1'b0;
        end
    end

    // Framing counters, shift registers and committed-frame outputs
    always_ff @(posedge clk_x4_i) begin
        if (!reset_ni) begin
            sync_q_r              <= 2'd0;
            smux_frame_r          <= 1'b0;
            user_sr_r             <= 4'd0;
            user_cnt_r            <= 2'd0;
            phase_r               <= 3'd0;
            nib_r                 <= {NIB_BITS{1'b0}};
            ch_r                  <= {CH_BITS{1'b0}};
            sample_r              <= {(SAMPLE_BITS-1){1'b0}};
            frame_slot_r          <= {CIRC_BUF_BITS{1'b0}};
            ram_addr_o            <= {(CIRC_BUF_BITS+CH_BITS){1'b0}};
            ram_data_o            <= {WORD_BITS{1'b0}};
            last_good_frame_idx_o <= {CIRC_BUF_BITS{1'b0}};
            user_bits_o           <= 4'd0;
            smux_o                <= 1'b0;
            has_sync_o            <= 1'b0;
            err_count_o           <= {ERR_CNT_BITS{1'b0}};
        end else if (!clk_main_tick_ni) begin
            if (state_r == StWaitSync) begin
                if (sync_i) begin
                    if (sync_q_r != 2'd3) begin
                        sync_q_r <= sync_q_r + 2'd1;
                    end
                end else begin
                    sync_q_r <= 2'd0;
                end
            end else begin
                sync_q_r <= 2'd0;
            end
            if (lock_lost_s) begin
                has_sync_o <= 1'b0;
            end
            if (start_s) begin
                smux_frame_r <= smux_i;
                user_cnt_r   <= 2'd0;
                phase_r      <= 3'd0;
                nib_r        <= {NIB_BITS{1'b0}};
                ch_r         <= {CH_BITS{1'b0}};
            end
            if (user_s) begin
                user_sr_r  <= {user_sr_r[2:0], bit_i};
                user_cnt_r <= user_cnt_r + 2'd1;
            end
            if (marker_s) begin
                phase_r <= 3'd1;
            end
            if (data_s) begin
                sample_r <= {sample_r[SAMPLE_BITS-3:0], bit_i};
                if (phase_r == 3'd4) begin
                    phase_r <= 3'd0;
                    if (nib_r == NIB_LAST) begin
                        nib_r <= {NIB_BITS{1'b0}};
                        ch_r  <= ch_r + CH_BITS'(1);
                    end else begin
                        nib_r <= nib_r + NIB_BITS'(1);
                    end
                end else begin
                    phase_r <= phase_r + 3'd1;
                end
            end
            if (write_s) begin
                ram_addr_o <= {frame_slot_r, slot_s};
                ram_data_o <= word_s;
            end
            if (commit_s) begin
                last_good_frame_idx_o <= frame_slot_r;
                frame_slot_r          <= frame_slot_r + CIRC_BUF_BITS'(1);
                user_bits_o           <= user_sr_r;
                smux_o                <= smux_frame_r;
                has_sync_o            <= 1'b1;
            end
            if (error_s) begin
                has_sync_o <= 1'b0;
                if (err_count_o != ERR_MAX) begin
                    err_count_o <= err_count_o + ERR_CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adat_frame_decoder_par.sv
// Directed bench for adat_frame_decoder_par: 8 channels x 24 bits, 8-slot buffer.
// A second instance with a 2-bit error counter shares the stimulus to exercise saturation.
module tb_adat_frame_decoder_par;
    logic        clk = 1'b0;
    logic        reset_n, tick_n, bit_in, valid_in, sync_in, smux_in;
    logic        ram_we, frame_valid, smux_out, has_sync;
    logic [5:0]  ram_addr;
    logic [31:0] ram_data;
    logic [2:0]  idx;
    logic [3:0]  user_bits;
    logic [7:0]  err_count;
    logic        e_ram_we, e_frame_valid, e_smux_out, e_has_sync;
    logic [5:0]  e_ram_addr;
    logic [31:0] e_ram_data;
    logic [2:0]  e_idx;
    logic [3:0]  e_user_bits;
    logic [1:0]  e_err_count;

    int tests_run = 0;
    int tests_failed = 0;
    int fv_count = 0;
    logic [5:0]  wr_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    adat_frame_decoder_par u_dut (
        .clk_x4_i(clk), .reset_ni(reset_n), .clk_main_tick_ni(tick_n), .bit_i(bit_in),
        .bit_valid_i(valid_in), .sync_i(sync_in), .smux_i(smux_in),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data),
        .frame_valid_o(frame_valid), .last_good_frame_idx_o(idx), .user_bits_o(user_bits),
        .smux_o(smux_out), .has_sync_o(has_sync), .err_count_o(err_count)
    );

    adat_frame_decoder_par #(.ERR_CNT_BITS(2)) u_dut_sat (
        .clk_x4_i(clk), .reset_ni(reset_n), .clk_main_tick_ni(tick_n), .bit_i(bit_in),
        .bit_valid_i(valid_in), .sync_i(sync_in), .smux_i(smux_in),
        .ram_we_o(e_ram_we), .ram_addr_o(e_ram_addr), .ram_data_o(e_ram_data),
        .frame_valid_o(e_frame_valid), .last_good_frame_idx_o(e_idx), .user_bits_o(e_user_bits),
        .smux_o(e_smux_out), .has_sync_o(e_has_sync), .err_count_o(e_err_count)
    );

    // Record every RAM write and frame-commit pulse of the main instance
    always @(negedge clk) begin
        if (ram_we) begin
            wr_q.push_back(ram_addr);
            wd_q.push_back(ram_data);
        end
        if (frame_valid) begin
            fv_count <= fv_count + 1;
        end
    end

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bit period: 3 idle clocks, then one tick clock
    task automatic send_bit(input logic b, input logic v, input logic s);
        bit_in   = b;
        valid_in = v;
        sync_in  = s;
        tick_n   = 1'b1;
        repeat (3) @(negedge clk);
        tick_n = 1'b0;
        @(negedge clk);
        tick_n = 1'b1;
    endtask

    // Full frame, channel c carries 0x111111*c. Optional fault, freeze or truncation point.
    task automatic send_frame(input logic [3:0] user, input int bad_ch, input int bad_nib,
                              input int bad_kind, input int hold_ch, input int hold_nib,
                              input int cut_ch, input int cut_nib);
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) send_bit(user[i], 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            logic [23:0] s;
            s = 24'(c) * 24'h111111;
            for (int n = 0; n < 6; n++) begin
                if (c == cut_ch && n == cut_nib) return;
                if (c == hold_ch && n == hold_nib) repeat (40) @(negedge clk);
                if (c == bad_ch && n == bad_nib) begin
                    case (bad_kind)
                        0:       send_bit(1'b0, 1'b1, 1'b0);
                        1:       send_bit(1'b1, 1'b0, 1'b0);
                        default: send_bit(1'b1, 1'b1, 1'b1);
                    endcase
                    send_bit(1'b0, 1'b1, 1'b0);
                    return;
                end
                send_bit(1'b1, 1'b1, 1'b0);
                for (int b = 3; b >= 0; b--) send_bit(s[(5 - n) * 4 + b], 1'b1, 1'b0);
            end
        end
        send_bit(1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_we"},   ram_we, 64'd0);
        check_eq({tag, "_addr"}, ram_addr, 64'd0);
        check_eq({tag, "_data"}, ram_data, 64'd0);
        check_eq({tag, "_fv"},   frame_valid, 64'd0);
        check_eq({tag, "_idx"},  idx, 64'd0);
        check_eq({tag, "_user"}, user_bits, 64'd0);
        check_eq({tag, "_smux"}, smux_out, 64'd0);
        check_eq({tag, "_sync"}, has_sync, 64'd0);
        check_eq({tag, "_err"},  err_count, 64'd0);
        check_eq({tag, "_eerr"}, e_err_count, 64'd0);
    endtask

    initial begin
        int fv0;
        reset_n = 1'b0; tick_n = 1'b1; bit_in = 1'b0;
        valid_in = 1'b0; sync_in = 1'b0; smux_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Test 1: normal frame into slot 0
        wr_q.delete(); wd_q.delete(); fv0 = fv_count;
        send_frame(4'hA, -1, -1, 0, -1, -1, -1, -1);
        @(negedge clk);
        check_eq("t1_nwr", wr_q.size(), 64'd8);
        for (int k = 0; k < 8; k++) check_eq("t1_addr", wr_q[k], 64'(k));
        check_eq("t1_ch3", wd_q[3], 64'h33333300);
        check_eq("t1_ch7", wd_q[7], 64'h77777700);
        check_eq("t1_fv", fv_count - fv0, 64'd1);
        check_eq("t1_fv_low", frame_valid, 64'd0);
        check_eq("t1_idx", idx, 64'd0);
        check_eq("t1_user", user_bits, 64'hA);
        check_eq("t1_sync", has_sync, 64'd1);
        check_eq("t1_smux", smux_out, 64'd0);

        // Test 2: SMUX2 frame into slot 1
        smux_in = 1'b1;
        wr_q.delete(); wd_q.delete();
        send_frame(4'h5, -1, -1, 0, -1, -1, -1, -1);
        @(negedge clk);
        smux_in = 1'b0;
        check_eq("t2_nwr", wr_q.size(), 64'd8);
        check_eq("t2_ch1_addr", wr_q[1], 64'd12);
        check_eq("t2_ch2_addr", wr_q[2], 64'd9);
        check_eq("t2_ch7_addr", wr_q[7], 64'd15);
        check_eq("t2_ch1_data", wd_q[1], 64'h11111100);
        check_eq("t2_smux", smux_out, 64'd1);
        check_eq("t2_idx", idx, 64'd1);
        check_eq("t2_user", user_bits, 64'h5);

        // Test 3: marker error in ch5 nibble 2, then slot 2 is reused
        wr_q.delete(); wd_q.delete(); fv0 = fv_count;
        send_frame(4'h3, 5, 2, 0, -1, -1, -1, -1);
        @(negedge clk);
        check_eq("t3_nwr", wr_q.size(), 64'd5);
        check_eq("t3_addr0", wr_q[0], 64'd16);
        check_eq("t3_err", err_count, 64'd1);
        check_eq("t3_sync", has_sync, 64'd0);
        check_eq("t3_idx", idx, 64'd1);
        check_eq("t3_fv", fv_count - fv0, 64'd0);
        wr_q.delete(); wd_q.delete();
        send_frame(4'h3, -1, -1, 0, -1, -1, -1, -1);
        @(negedge clk);
        check_eq("t3_reuse_addr0", wr_q[0], 64'd16);
        check_eq("t3_reuse_nwr", wr_q.size(), 64'd8);
        check_eq("t3_reuse_idx", idx, 64'd2);
        check_eq("t3_reuse_sync", has_sync, 64'd1);

        // Test 5: tick held high mid-ch4 freezes state; then reset on a non-tick clock
        wr_q.delete(); wd_q.delete();
        send_frame(4'hC, -1, -1, 0, 4, 2, -1, -1);
        @(negedge clk);
        check_eq("t5_hold_nwr", wr_q.size(), 64'd8);
        check_eq("t5_hold_addr4", wr_q[4], 64'd28);
        check_eq("t5_hold_ch4", wd_q[4], 64'h44444400);
        check_eq("t5_hold_idx", idx, 64'd3);
        check_eq("t5_hold_user", user_bits, 64'hC);
        send_frame(4'h6, -1, -1, 0, -1, -1, 4, 3);
        check_eq("t5_pre_data", ram_data, 64'h33333300);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("t5_rst");
        reset_n = 1'b1;

        // Test 4: nine good frames, index walks 0..7 then wraps to 0
        for (int f = 0; f < 9; f++) begin
            wr_q.delete(); wd_q.delete();
            send_frame(4'(f), -1, -1, 0, -1, -1, -1, -1);
            @(negedge clk);
            check_eq("t4_idx", idx, 64'(f % 8));
            if (f == 8) begin
                check_eq("t4_f9_nwr", wr_q.size(), 64'd8);
                for (int k = 0; k < 8; k++) check_eq("t4_f9_addr", wr_q[k], 64'(k));
            end
        end

        // Test 6: five aborted frames, 2-bit counter saturates at 3
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send_frame(4'h0, 0, 0, (i - 1) % 3, -1, -1, -1, -1);
            @(negedge clk);
            check_eq("t6_err_sat", e_err_count, 64'((i > 3) ? 3 : i));
            check_eq("t6_err_wide", err_count, 64'(i));
            check_eq("t6_sync", has_sync, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
